depacketizer_mm2s: RTL and testbench



---
 rtl/depacketizer_mm2s.sv | 225 ++++++++++++++++++++++
 tb/tb_depacketizer_mm2s.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/depacketizer_mm2s.sv
// depacketizer_mm2s
//   Turns the TLAST-framed AXI-Stream MM2S output of the AXI DMA into a plain
//   sample stream. Each packet is checked against a configured beat count,
//   completed packets are counted, framing errors are latched, and a one-cycle
//   packet_done pulse is emitted per packet.
//
// Ports
//   aclk, aresetn           clock, asynchronous active-low reset
//   s_axis_mm2s_*           AXI-Stream input from the DMA (tdata/tvalid/tready/tlast)
//   m_axis_data_*           AXI-Stream output to the sample manager (tdata/tvalid/tready)
//   packet_done             one-cycle pulse after the final beat of each packet
//   error                   OR of the sticky ERROR bits
//   s_axi_lite_*            AXI4-Lite subordinate for CONFIG/STATUS/PACKETS/ERROR
module depacketizer_mm2s #(
    parameter logic [31:0] AddrConfig  = 32'h0000_0200,
    parameter logic [31:0] AddrStatus  = 32'h0000_0204,
    parameter logic [31:0] AddrPackets = 32'h0000_0208,
    parameter logic [31:0] AddrError   = 32'h0000_020C
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] s_axis_mm2s_tdata,
    input  logic        s_axis_mm2s_tvalid,
    output logic        s_axis_mm2s_tready,
    input  logic        s_axis_mm2s_tlast,
    output logic [31:0] m_axis_data_tdata,
    output logic        m_axis_data_tvalid,
    input  logic        m_axis_data_tready,
    output logic        packet_done,
    output logic        error,
    input  logic [31:0] s_axi_lite_awaddr,
    input  logic [2:0]  s_axi_lite_awprot,
    input  logic        s_axi_lite_awvalid,
    output logic        s_axi_lite_awready,
    input  logic [31:0] s_axi_lite_wdata,
    input  logic [3:0]  s_axi_lite_wstrb,
    input  logic        s_axi_lite_wvalid,
    output logic        s_axi_lite_wready,
    output logic [1:0]  s_axi_lite_bresp,
    output logic        s_axi_lite_bvalid,
    input  logic        s_axi_lite_bready,
    input  logic [31:0] s_axi_lite_araddr,
    input  logic [2:0]  s_axi_lite_arprot,
    input  logic        s_axi_lite_arvalid,
    output logic        s_axi_lite_arready,
    output logic [31:0] s_axi_lite_rdata,
    output logic [1:0]  s_axi_lite_rresp,
    output logic        s_axi_lite_rvalid,
    input  logic        s_axi_lite_rready
);
    localparam logic [9:0] IdxConfig  = AddrConfig[11:2];
    localparam logic [9:0] IdxStatus  = AddrStatus[11:2];
    localparam logic [9:0] IdxPackets = AddrPackets[11:2];
    localparam logic [9:0] IdxError   = AddrError[11:2];
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    logic [31:0] r_config, r_cnt, r_packets;
    logic [1:0]  r_err;
    logic        r_packet_done, r_error, r_rst_done;
    logic        r_aw_held, r_w_held, r_bvalid;
    logic [9:0]  r_aw_idx;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [1:0]  r_bresp;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic [1:0]  r_rresp;

    logic        w_en, w_beat, w_at_e, w_end;
    logic [31:0] w_last_idx;
    logic [1:0]  w_err_set, w_err_clr, w_err_nxt;
    logic        w_aw_hs, w_w_hs, w_ar_hs, w_wr_exec, w_cfg_we;
    logic [1:0]  w_wr_resp, w_rd_resp;
    logic [31:0] w_rd_data;
    logic        w_unused;

    function automatic logic [31:0] merge_strb(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++)
            res[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        return res;
    endfunction

    // Zero-latency pass-through; CONFIG = 0 blocks the stream in both directions.
    assign w_en               = (r_config != 32'd0);
    assign m_axis_data_tdata  = s_axis_mm2s_tdata;
    assign m_axis_data_tvalid = s_axis_mm2s_tvalid & w_en;
    assign s_axis_mm2s_tready = m_axis_data_tready & w_en;

    assign w_beat     = s_axis_mm2s_tvalid & s_axis_mm2s_tready;
    assign w_last_idx = r_config - 32'd1;
    assign w_at_e     = (r_cnt == w_last_idx);
    assign w_end      = s_axis_mm2s_tlast | w_at_e;
    // bit0 EARLY: tlast before the expected last beat; bit1 LATE: no tlast on it.
    assign w_err_set  = {w_beat & ~s_axis_mm2s_tlast & w_at_e,
                         w_beat &  s_axis_mm2s_tlast & ~w_at_e};
    // Set is ORed in after the clear so a simultaneous set wins.
    assign w_err_nxt  = (r_err & ~w_err_clr) | w_err_set;

    // Readies stay low while in reset and for the first cycle after it.
    assign s_axi_lite_awready = r_rst_done & ~r_aw_held & ~r_bvalid;
    assign s_axi_lite_wready  = r_rst_done & ~r_w_held & ~r_bvalid;
    assign s_axi_lite_arready = r_rst_done & ~r_rvalid;
    assign s_axi_lite_bvalid  = r_bvalid;
    assign s_axi_lite_bresp   = r_bresp;
    assign s_axi_lite_rvalid  = r_rvalid;
    assign s_axi_lite_rdata   = r_rdata;
    assign s_axi_lite_rresp   = r_rresp;
    assign packet_done        = r_packet_done;
    assign error              = r_error;

    assign w_aw_hs   = s_axi_lite_awvalid & s_axi_lite_awready;
    assign w_w_hs    = s_axi_lite_wvalid & s_axi_lite_wready;
    assign w_ar_hs   = s_axi_lite_arvalid & s_axi_lite_arready;
    assign w_wr_exec = r_aw_held & r_w_held;

    always_comb begin
        w_cfg_we  = 1'b0;
        w_err_clr = 2'b00;
        w_wr_resp = RespSlverr;
        case (r_aw_idx)
            IdxConfig: if (r_cnt == 32'd0) begin
                w_cfg_we  = w_wr_exec;
                w_wr_resp = RespOkay;
            end
            IdxError: begin
                w_err_clr = (w_wr_exec & r_wstrb[0]) ? r_wdata[1:0] : 2'b00;
                w_wr_resp = RespOkay;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_rd_data = 32'd0;
        w_rd_resp = RespOkay;
        case (s_axi_lite_araddr[11:2])
            IdxConfig:  w_rd_data = r_config;
            IdxStatus:  w_rd_data = r_cnt;
            IdxPackets: w_rd_data = r_packets;
            IdxError:   w_rd_data = {30'd0, r_err};
            default:    w_rd_resp = RespSlverr;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_config      <= 32'd0;
            r_cnt         <= 32'd0;
            r_packets     <= 32'd0;
            r_err         <= 2'b00;
            r_packet_done <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            if (w_cfg_we)
                r_config <= merge_strb(r_config, r_wdata, r_wstrb);
            if (w_beat) begin
                if (w_end) begin
                    r_cnt     <= 32'd0;
                    r_packets <= r_packets + 32'd1;
                end else begin
                    r_cnt <= r_cnt + 32'd1;
                end
            end
            r_packet_done <= w_beat & w_end;
            r_err         <= w_err_nxt;
            r_error       <= |w_err_nxt;
        end
    end

    // Write channel: AW and W are latched independently; the write fires once both are held.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rst_done <= 1'b0;
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_aw_idx   <= 10'd0;
            r_wdata    <= 32'd0;
            r_wstrb    <= 4'd0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RespOkay;
        end else begin
            r_rst_done <= 1'b1;
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_aw_idx  <= s_axi_lite_awaddr[11:2];
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= s_axi_lite_wdata;
                r_wstrb  <= s_axi_lite_wstrb;
            end
            if (w_wr_exec) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_wr_resp;
            end else if (r_bvalid & s_axi_lite_bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rvalid <= 1'b0;
            r_rdata  <= 32'd0;
            r_rresp  <= RespOkay;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_data;
            r_rresp  <= w_rd_resp;
        end else if (r_rvalid & s_axi_lite_rready) begin
            r_rvalid <= 1'b0;
        end
    end

    // Protection bits and address bits outside [11:2] carry no meaning here.
    assign w_unused = ^{s_axi_lite_awprot, s_axi_lite_arprot,
                        s_axi_lite_awaddr[31:12], s_axi_lite_awaddr[1:0],
                        s_axi_lite_araddr[31:12], s_axi_lite_araddr[1:0]};
endmodule

// File: tb/tb_depacketizer_mm2s.sv
module tb_depacketizer_mm2s;
    localparam logic [31:0] A_CFG = 32'h200, A_ST = 32'h204, A_PK = 32'h208, A_ERR = 32'h20C;

    logic        aclk = 1'b0, aresetn = 1'b0;
    logic [31:0] s_axis_mm2s_tdata = '0;
    logic        s_axis_mm2s_tvalid = 1'b0, s_axis_mm2s_tready, s_axis_mm2s_tlast = 1'b0;
    logic [31:0] m_axis_data_tdata;
    logic        m_axis_data_tvalid, m_axis_data_tready = 1'b0;
    logic        packet_done, error;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata;
    logic [2:0]  awprot = '0, arprot = '0;
    logic [3:0]  wstrb = '0;
    logic        awvalid = 1'b0, awready, wvalid = 1'b0, wready, bvalid, bready = 1'b0;
    logic        arvalid = 1'b0, arready, rvalid, rready = 1'b0;
    logic [1:0]  bresp, rresp;

    depacketizer_mm2s dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_mm2s_tdata(s_axis_mm2s_tdata), .s_axis_mm2s_tvalid(s_axis_mm2s_tvalid),
        .s_axis_mm2s_tready(s_axis_mm2s_tready), .s_axis_mm2s_tlast(s_axis_mm2s_tlast),
        .m_axis_data_tdata(m_axis_data_tdata), .m_axis_data_tvalid(m_axis_data_tvalid),
        .m_axis_data_tready(m_axis_data_tready),
        .packet_done(packet_done), .error(error),
        .s_axi_lite_awaddr(awaddr), .s_axi_lite_awprot(awprot),
        .s_axi_lite_awvalid(awvalid), .s_axi_lite_awready(awready),
        .s_axi_lite_wdata(wdata), .s_axi_lite_wstrb(wstrb),
        .s_axi_lite_wvalid(wvalid), .s_axi_lite_wready(wready),
        .s_axi_lite_bresp(bresp), .s_axi_lite_bvalid(bvalid), .s_axi_lite_bready(bready),
        .s_axi_lite_araddr(araddr), .s_axi_lite_arprot(arprot),
        .s_axi_lite_arvalid(arvalid), .s_axi_lite_arready(arready),
        .s_axi_lite_rdata(rdata), .s_axi_lite_rresp(rresp),
        .s_axi_lite_rvalid(rvalid), .s_axi_lite_rready(rready)
    );

    always #5 aclk = ~aclk;

    int checks = 0, errors = 0;
    int pd_count = 0;
    always @(negedge aclk) if (packet_done) pd_count++;

    typedef struct {
        logic [31:0] cfg;
        int          nbeats;
        logic [15:0] last_mask;
        logic [31:0] exp_pk;
        logic [31:0] exp_err;
        logic [31:0] exp_st;
    } vec_t;
    vec_t vecs[6];

    logic [31:0] txq[$], rxq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        s_axis_mm2s_tvalid = 1'b0; s_axis_mm2s_tlast = 1'b0; m_axis_data_tready = 1'b1;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        #2 aresetn = 1'b1;
        tick();
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int w_delay, output logic [1:0] resp, output int b_cycle);
        bit aw_acc, w_acc, b_acc, got_b, w_issued;
        got_b = 0; w_issued = 0; b_cycle = -1; resp = 2'b11;
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; bready = 1'b1;
        for (int i = 0; i < 40 && !got_b; i++) begin
            if (!w_issued && i >= w_delay) begin wvalid = 1'b1; w_issued = 1; end
            #1;
            aw_acc = awvalid && awready;
            w_acc  = wvalid && wready;
            b_acc  = bvalid && bready;
            if (bvalid && b_cycle < 0) b_cycle = i;
            if (b_acc) resp = bresp;
            tick();
            if (aw_acc) awvalid = 1'b0;
            if (w_acc) wvalid = 1'b0;
            if (b_acc) got_b = 1;
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
        if (!got_b) check("write_timeout", 32'd0, 32'd1);
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        bit ar_acc, r_acc, got_r;
        got_r = 0; data = 32'hDEAD_BEEF; resp = 2'b11;
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        for (int i = 0; i < 40 && !got_r; i++) begin
            #1;
            ar_acc = arvalid && arready;
            r_acc  = rvalid && rready;
            if (r_acc) begin data = rdata; resp = rresp; end
            tick();
            if (ar_acc) arvalid = 1'b0;
            if (r_acc) got_r = 1;
        end
        arvalid = 1'b0; rready = 1'b0;
        if (!got_r) check("read_timeout", 32'd0, 32'd1);
    endtask

    task automatic read_check(input string name, input logic [31:0] addr,
                              input logic [31:0] exp_data, input logic [1:0] exp_resp);
        logic [31:0] d;
        logic [1:0]  r;
        axi_read(addr, d, r);
        check({name, "_data"}, d, exp_data);
        check({name, "_resp"}, 32'(r), 32'(exp_resp));
    endtask

    // One beat with downstream always ready; data must appear on the output the same cycle.
    task automatic send_beat(input logic [31:0] data, input logic last);
        bit ok;
        ok = 0;
        s_axis_mm2s_tdata = data; s_axis_mm2s_tlast = last; s_axis_mm2s_tvalid = 1'b1;
        #1;
        for (int i = 0; i < 20; i++) begin
            if (s_axis_mm2s_tready) begin
                ok = 1;
                check("pass_tvalid", 32'(m_axis_data_tvalid), 32'd1);
                check("pass_tdata", m_axis_data_tdata, data);
                break;
            end
            tick();
        end
        tick();
        s_axis_mm2s_tvalid = 1'b0; s_axis_mm2s_tlast = 1'b0;
        if (!ok) check("beat_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp;
        logic [31:0] d;
        int          bc, pd_base, sent;
        bit          hs;

        vecs[0] = '{cfg: 32'd4, nbeats: 8, last_mask: 16'h0088, exp_pk: 32'd2, exp_err: 32'd0, exp_st: 32'd0};
        vecs[1] = '{cfg: 32'd4, nbeats: 6, last_mask: 16'h0022, exp_pk: 32'd2, exp_err: 32'd1, exp_st: 32'd0};
        vecs[2] = '{cfg: 32'd3, nbeats: 6, last_mask: 16'h0000, exp_pk: 32'd2, exp_err: 32'd2, exp_st: 32'd0};
        vecs[3] = '{cfg: 32'd4, nbeats: 3, last_mask: 16'h0000, exp_pk: 32'd0, exp_err: 32'd0, exp_st: 32'd3};
        vecs[4] = '{cfg: 32'd2, nbeats: 5, last_mask: 16'h0010, exp_pk: 32'd3, exp_err: 32'd3, exp_st: 32'd0};
        vecs[5] = '{cfg: 32'd1, nbeats: 3, last_mask: 16'h0002, exp_pk: 32'd3, exp_err: 32'd2, exp_st: 32'd0};

        // Reset state, checked while aresetn is still low.
        m_axis_data_tready = 1'b1; s_axis_mm2s_tvalid = 1'b1;
        #12;
        check("rst_tready", 32'(s_axis_mm2s_tready), 32'd0);
        check("rst_m_tvalid", 32'(m_axis_data_tvalid), 32'd0);
        check("rst_packet_done", 32'(packet_done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_readies", 32'({awready, wready, arready}), 32'd0);
        check("rst_valids", 32'({bvalid, rvalid}), 32'd0);
        s_axis_mm2s_tvalid = 1'b0;
        @(negedge aclk) aresetn = 1'b1;
        tick();
        read_check("rst_cfg", A_CFG, 32'd0, 2'b00);
        read_check("rst_status", A_ST, 32'd0, 2'b00);
        read_check("rst_packets", A_PK, 32'd0, 2'b00);
        read_check("rst_err", A_ERR, 32'd0, 2'b00);

        // Byte strobes on CONFIG.
        axi_write(A_CFG, 32'hAABB_CCDD, 4'b0101, 0, resp, bc);
        check("strb_resp", 32'(resp), 32'd0);
        read_check("strb_cfg", A_CFG, 32'h00BB_00DD, 2'b00);

        // Table-driven packet framing vectors.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            axi_write(A_CFG, vecs[v].cfg, 4'hF, 0, resp, bc);
            check($sformatf("v%0d_cfg_resp", v), 32'(resp), 32'd0);
            pd_base = pd_count;
            for (int b = 0; b < vecs[v].nbeats; b++)
                send_beat($urandom, vecs[v].last_mask[b]);
            tick(); tick();
            check($sformatf("v%0d_pulses", v), 32'(pd_count - pd_base), vecs[v].exp_pk);
            check($sformatf("v%0d_error_out", v), 32'(error), 32'(vecs[v].exp_err != 0));
            read_check($sformatf("v%0d_packets", v), A_PK, vecs[v].exp_pk, 2'b00);
            read_check($sformatf("v%0d_err", v), A_ERR, vecs[v].exp_err, 2'b00);
            read_check($sformatf("v%0d_status", v), A_ST, vecs[v].exp_st, 2'b00);
        end

        // EARLY then write-1-to-clear.
        do_reset();
        axi_write(A_CFG, 32'd4, 4'hF, 0, resp, bc);
        send_beat(32'h1111_0001, 1'b1);
        tick();
        check("early_error_out", 32'(error), 32'd1);
        axi_write(A_ERR, 32'd1, 4'hF, 0, resp, bc);
        check("w1c_resp", 32'(resp), 32'd0);
        check("w1c_error_out", 32'(error), 32'd0);
        read_check("w1c_err", A_ERR, 32'd0, 2'b00);
        read_check("w1c_packets", A_PK, 32'd1, 2'b00);

        // Disabled stream, then enable.
        do_reset();
        s_axis_mm2s_tvalid = 1'b1; s_axis_mm2s_tdata = 32'h5A5A_0000;
        repeat (3) tick();
        check("dis_tready", 32'(s_axis_mm2s_tready), 32'd0);
        check("dis_m_tvalid", 32'(m_axis_data_tvalid), 32'd0);
        s_axis_mm2s_tvalid = 1'b0;
        read_check("dis_status", A_ST, 32'd0, 2'b00);
        read_check("dis_packets", A_PK, 32'd0, 2'b00);
        axi_write(A_CFG, 32'd2, 4'hF, 0, resp, bc);
        s_axis_mm2s_tvalid = 1'b1;
        #1;
        check("en_tready", 32'(s_axis_mm2s_tready), 32'd1);
        check("en_m_tvalid", 32'(m_axis_data_tvalid), 32'd1);
        s_axis_mm2s_tvalid = 1'b0;

        // Mid-packet CONFIG write with W three cycles after AW; unmapped accesses.
        do_reset();
        axi_write(A_CFG, 32'd4, 4'hF, 0, resp, bc);
        send_beat(32'h2222_0001, 1'b0);
        read_check("mid_status", A_ST, 32'd1, 2'b00);
        axi_write(A_CFG, 32'd8, 4'hF, 3, resp, bc);
        check("mid_cfg_resp", 32'(resp), 32'd2);
        check("mid_b_after_w", 32'(bc > 3), 32'd1);
        check("mid_single_b", 32'(bvalid), 32'd0);
        read_check("mid_cfg", A_CFG, 32'd4, 2'b00);
        axi_write(A_ST, 32'd7, 4'hF, 0, resp, bc);
        check("ro_status_resp", 32'(resp), 32'd2);
        read_check("unmapped", 32'h210, 32'd0, 2'b10);

        // Random backpressure on both sides: every sample must arrive once, in order.
        do_reset();
        axi_write(A_CFG, 32'd16, 4'hF, 0, resp, bc);
        txq.delete(); rxq.delete();
        sent = 0; pd_base = pd_count;
        for (int cyc = 0; cyc < 3000 && sent < 64; cyc++) begin
            if (!s_axis_mm2s_tvalid && $urandom_range(0, 3) != 0) begin
                s_axis_mm2s_tvalid = 1'b1;
                s_axis_mm2s_tdata  = $urandom;
                s_axis_mm2s_tlast  = ((sent % 16) == 15);
            end
            m_axis_data_tready = 1'($urandom_range(0, 1));
            #1;
            if (m_axis_data_tvalid && m_axis_data_tready) rxq.push_back(m_axis_data_tdata);
            hs = s_axis_mm2s_tvalid && s_axis_mm2s_tready;
            if (hs) begin txq.push_back(s_axis_mm2s_tdata); sent++; end
            tick();
            if (hs) begin s_axis_mm2s_tvalid = 1'b0; s_axis_mm2s_tlast = 1'b0; end
        end
        s_axis_mm2s_tvalid = 1'b0; m_axis_data_tready = 1'b1;
        tick(); tick();
        check("rnd_sent", 32'(sent), 32'd64);
        check("rnd_rx_count", 32'(rxq.size()), 32'(txq.size()));
        for (int i = 0; i < txq.size() && i < rxq.size(); i++)
            check($sformatf("rnd_sample%0d", i), rxq[i], txq[i]);
        check("rnd_pulses", 32'(pd_count - pd_base), 32'(sent / 16));
        read_check("rnd_packets", A_PK, 32'd4, 2'b00);
        read_check("rnd_err", A_ERR, 32'd0, 2'b00);
        read_check("rnd_status", A_ST, 32'd0, 2'b00);

        // Asynchronous reset in the middle of a packet with an error pending.
        send_beat(32'h3333_0001, 1'b1);
        send_beat(32'h3333_0002, 1'b0);
        send_beat(32'h3333_0003, 1'b0);
        check("pre_rst_error", 32'(error), 32'd1);
        read_check("pre_rst_status", A_ST, 32'd2, 2'b00);
        s_axis_mm2s_tvalid = 1'b1;
        #2 aresetn = 1'b0;
        #1;
        check("arst_tready", 32'(s_axis_mm2s_tready), 32'd0);
        check("arst_m_tvalid", 32'(m_axis_data_tvalid), 32'd0);
        check("arst_error", 32'(error), 32'd0);
        check("arst_packet_done", 32'(packet_done), 32'd0);
        check("arst_valids", 32'({bvalid, rvalid}), 32'd0);
        s_axis_mm2s_tvalid = 1'b0;
        @(negedge aclk) aresetn = 1'b1;
        tick();
        read_check("arst_cfg", A_CFG, 32'd0, 2'b00);
        read_check("arst_status", A_ST, 32'd0, 2'b00);
        read_check("arst_packets", A_PK, 32'd0, 2'b00);
        read_check("arst_err", A_ERR, 32'd0, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
